// File: rtl/imem_writer_pkg.sv
// Shared types and constants for the instruction-RAM loader.
package imem_writer_pkg;

  localparam int unsigned DEPTH_DEFAULT  = 128;
  localparam int unsigned ADDR_W_DEFAULT = 7;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = WORD_W / BYTE_W;
  localparam int unsigned LANE_W         = 2;
  localparam int unsigned LEN_W          = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECV   = 2'd1,
    ST_WRITE  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/imem_writer_word_packer.sv
// Assembles a little-endian 32-bit word from a byte stream; o_word already
// contains the byte presented this cycle so the completing byte needs no extra cycle.
module word_packer
  import imem_writer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_byte_valid,
  input  logic [BYTE_W-1:0] i_byte,
  input  logic              i_clear,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_full
);

  logic [WORD_W-1:0] r_word;
  logic [LANE_W-1:0] r_lane;
  logic [WORD_W-1:0] w_word;

  always_comb begin
    w_word = r_word;
    case (r_lane)
      2'd0:    w_word[7:0]   = i_byte;
      2'd1:    w_word[15:8]  = i_byte;
      2'd2:    w_word[23:16] = i_byte;
      default: w_word[31:24] = i_byte;
    endcase
  end

  assign o_word      = w_word;
  assign o_word_full = i_byte_valid && (r_lane == LANE_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_word <= '0;
      r_lane <= '0;
    end else if (i_clear) begin
      r_word <= '0;
      r_lane <= '0;
    end else if (i_byte_valid) begin
      r_word <= w_word;
      r_lane <= r_lane + LANE_W'(1);
    end
  end

endmodule

// File: rtl/imem_writer.sv
// Loads a byte stream into instruction RAM word by word, holding the CPU via busy
// and reporting an XOR checksum of the written words on completion.
module imem_writer
  import imem_writer_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEFAULT,
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  length,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [WORD_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [WORD_W-1:0] checksum
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              w_load;
  logic              w_cap;
  logic              w_commit;
  logic              w_inc;
  logic              w_err;
  logic              w_last;
  logic              w_len_big;
  logic              w_byte_valid;
  logic              w_clear;
  logic              w_word_full;
  logic [WORD_W-1:0] w_word;

  logic [LEN_W-1:0]  r_len;
  logic [ADDR_W-1:0] r_word_cnt;
  logic [ADDR_W-1:0] r_waddr;
  logic [WORD_W-1:0] r_wdata;
  logic [WORD_W-1:0] r_checksum;
  logic              r_we;
  logic              r_in_ready;
  logic              r_busy;
  logic              r_done;
  logic              r_error;

  assign w_byte_valid = in_valid && r_in_ready;
  assign w_clear      = (r_state == ST_IDLE) || (r_state == ST_FINISH);
  assign w_last       = (32'(r_word_cnt) + 32'd1) == 32'(r_len);
  assign w_len_big    = 32'(length) > DEPTH;

  word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .i_byte_valid (w_byte_valid),
    .i_byte       (in_data),
    .i_clear      (w_clear),
    .o_word       (w_word),
    .o_word_full  (w_word_full)
  );

  // Next-state and datapath control
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_cap       = 1'b0;
    w_commit    = 1'b0;
    w_inc       = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (length == '0) begin
            w_state_nxt = ST_FINISH;
          end else if (w_len_big) begin
            w_err = 1'b1;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = ST_RECV;
          end
        end
      end
      ST_RECV: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_word_full) begin
          w_cap       = 1'b1;
          w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_commit = 1'b1;
          if (w_last) begin
            w_state_nxt = ST_FINISH;
          end else begin
            w_inc       = 1'b1;
            w_state_nxt = ST_RECV;
          end
        end
      end
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Status outputs registered from the next state so they line up with it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_we       <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_in_ready <= (w_state_nxt == ST_RECV);
      r_busy     <= (w_state_nxt == ST_RECV) || (w_state_nxt == ST_WRITE);
      r_we       <= (w_state_nxt == ST_WRITE);
      r_done     <= (w_state_nxt == ST_FINISH);
      r_error    <= w_err;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len      <= '0;
      r_word_cnt <= '0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_checksum <= '0;
    end else begin
      if (w_load) begin
        r_len      <= length;
        r_word_cnt <= '0;
        r_checksum <= '0;
      end
      if (w_cap) begin
        r_waddr <= r_word_cnt;
        r_wdata <= w_word;
      end
      if (w_commit) begin
        r_checksum <= r_checksum ^ r_wdata;
      end
      if (w_inc) begin
        r_word_cnt <= r_word_cnt + ADDR_W'(1);
      end
    end
  end

  // An abort during the write cycle suppresses the strobe itself
  assign we       = r_we && !abort;
  assign in_ready = r_in_ready;
  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;
  assign waddr    = r_waddr;
  assign wdata    = r_wdata;
  assign checksum = r_checksum;

endmodule

// File: tb/tb_imem_writer.sv
// Directed self-checking bench for imem_writer.
module tb_imem_writer;
  import imem_writer_pkg::*;

  localparam int unsigned ADDR_W = 7;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        length;
  logic              abort;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic              error;
  logic [31:0]       checksum;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          done_cnt;
  int          err_cnt;
  logic [31:0] done_ck;

  imem_writer #(.DEPTH(128), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .length   (length),
    .abort    (abort),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we === 1'b1) begin
      wr_addr.push_back(32'(waddr));
      wr_data.push_back(wdata);
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_ck = checksum;
    end
    if (error === 1'b1) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  task automatic pulse_start(input logic [7:0] len);
    start  = 1'b1;
    length = len;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) check("ready_wait", 32'(in_ready), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    wait_ready();
    tick();
    in_valid = 1'b0;
  endtask

  logic [7:0] t4_bytes [4];
  int         idx;
  logic       hs;

  initial begin
    reset = 1'b0; start = 1'b0; length = '0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0;
    clear_mon();
    done_ck = '0;
    t4_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    // Reset state
    tick(); tick();
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_we",       32'(we),       0);
    check("rst_busy",     32'(busy),     0);
    check("rst_done",     32'(done),     0);
    check("rst_error",    32'(error),    0);
    check("rst_waddr",    32'(waddr),    0);
    check("rst_wdata",    wdata,         0);
    check("rst_checksum", checksum,      0);
    reset = 1'b1;
    tick();

    // Two-word load
    clear_mon();
    pulse_start(8'd2);
    check("t1_busy",  32'(busy),     1);
    check("t1_ready", 32'(in_ready), 1);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check("t1_lat_we",    32'(we),    1);
    check("t1_lat_waddr", 32'(waddr), 0);
    check("t1_lat_wdata", wdata,      32'h0000_0013);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    repeat (4) tick();
    check("t1_nwr",   32'(wr_addr.size()), 2);
    check("t1_addr0", wr_addr[0], 0);
    check("t1_data0", wr_data[0], 32'h0000_0013);
    check("t1_addr1", wr_addr[1], 1);
    check("t1_data1", wr_data[1], 32'h0010_0093);
    check("t1_done",  32'(done_cnt), 1);
    check("t1_csum",  done_ck, 32'h0010_0080);
    check("t1_idle_busy", 32'(busy), 0);
    check("t1_hold_wdata", wdata, 32'h0010_0093);

    // Zero-length load
    clear_mon();
    pulse_start(8'd0);
    check("t2_done",  32'(done), 1);
    check("t2_busy",  32'(busy), 0);
    tick();
    check("t2_done_off", 32'(done), 0);
    repeat (2) tick();
    check("t2_nwr", 32'(wr_addr.size()), 0);

    // Oversized load
    clear_mon();
    pulse_start(8'd200);
    check("t3_error", 32'(error),    1);
    check("t3_busy",  32'(busy),     0);
    check("t3_ready", 32'(in_ready), 0);
    tick();
    check("t3_error_off", 32'(error), 0);
    check("t3_busy2",     32'(busy),  0);
    check("t3_ready2",    32'(in_ready), 0);
    check("t3_ndone",     32'(done_cnt), 0);

    // Length boundary: DEPTH accepted, DEPTH+1 rejected
    clear_mon();
    pulse_start(8'd128);
    check("bnd128_error", 32'(error), 0);
    check("bnd128_busy",  32'(busy),  1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("bnd128_abort", 32'(busy), 0);
    pulse_start(8'd129);
    check("bnd129_error", 32'(error), 1);
    check("bnd129_busy",  32'(busy),  0);

    // Single word with in_valid toggling every cycle
    clear_mon();
    pulse_start(8'd1);
    idx = 0;
    for (int c = 0; c < 40 && idx < 4; c++) begin
      in_valid = c[0];
      in_data  = t4_bytes[idx];
      hs = in_valid && in_ready;
      tick();
      if (hs) idx++;
    end
    in_valid = 1'b0;
    check("t4_bytes", 32'(idx), 4);
    repeat (4) tick();
    check("t4_nwr",  32'(wr_addr.size()), 1);
    check("t4_addr", wr_addr[0], 0);
    check("t4_data", wr_data[0], 32'hDDCC_BBAA);
    check("t4_done", 32'(done_cnt), 1);
    check("t4_csum", done_ck, 32'hDDCC_BBAA);

    // Abort together with the last byte of word 3
    clear_mon();
    pulse_start(8'd8);
    for (int w = 0; w < 3; w++)
      for (int b = 0; b < 4; b++)
        send_byte(8'(w * 4 + b));
    send_byte(8'h30); send_byte(8'h31); send_byte(8'h32);
    in_valid = 1'b1;
    in_data  = 8'h33;
    wait_ready();
    abort = 1'b1;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    check("t5_we",    32'(we),       0);
    check("t5_busy",  32'(busy),     0);
    check("t5_ready", 32'(in_ready), 0);
    repeat (4) tick();
    check("t5_nwr",   32'(wr_addr.size()), 3);
    check("t5_last",  wr_addr[2], 2);
    check("t5_ndone", 32'(done_cnt), 0);
    check("t5_idle",  32'(busy), 0);

    // Reset mid-load, then a fresh single-word load
    clear_mon();
    pulse_start(8'd4);
    send_byte(8'hA0); send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
    send_byte(8'hB0);
    reset = 1'b0;
    #1;
    check("t6_rst_busy",  32'(busy),  0);
    check("t6_rst_we",    32'(we),    0);
    check("t6_rst_waddr", 32'(waddr), 0);
    check("t6_rst_wdata", wdata,      0);
    check("t6_rst_csum",  checksum,   0);
    tick(); tick();
    reset = 1'b1;
    clear_mon();
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) tick();
    check("t6_no_ready", 32'(in_ready), 0);
    in_valid = 1'b0;
    check("t6_no_wr", 32'(wr_addr.size()), 0);
    pulse_start(8'd1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    check("t6_we",    32'(we),    1);
    check("t6_waddr", 32'(waddr), 0);
    check("t6_wdata", wdata,      32'h4433_2211);
    repeat (3) tick();
    check("t6_nwr",  32'(wr_addr.size()), 1);
    check("t6_done", 32'(done_cnt), 1);
    check("t6_csum", done_ck, 32'h4433_2211);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
